// File: rtl/uart_pkg.sv
// Shared types and constants for the streaming UART transmitter.
// Holds the FSM state encoding, parity mode codes and bit-time helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per line bit; clamped so a misconfigured baud never yields a zero-length bit.
    function automatic int cycles_per_bit(input int clk_hz, input int baud);
        int c;
        c = clk_hz / baud;
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/uart_tx_stream_if.sv
// Valid/ready word stream feeding the UART transmitter FIFO.
// The producer drives data and valid; the transmitter answers with ready.
interface uart_tx_stream_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth and a registered read port.
// pop_data is updated on the edge that pops and holds until the next pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] pop_data_reg;
    logic             push_en;
    logic             pop_en;

    assign full     = (count_reg == CW'(DEPTH));
    assign empty    = (count_reg == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign count    = count_reg;
    assign pop_data = pop_data_reg;

    // Storage has no reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            pop_data_reg <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                pop_data_reg <= mem[rd_ptr_reg];
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_stream.sv
// FIFO-buffered UART transmitter: start, DATA_BITS data, optional parity, stop bits.
// tx_out is registered from the current state, so the line trails the FSM by one clock.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_stream_if.slave               s,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CYCLES      = cycles_per_bit(CLK_HZ, BAUD);
    localparam int STOP_CYCLES = STOP_BITS * CYCLES;
    localparam int CYC_W       = $clog2(STOP_CYCLES + 1);
    localparam int BIT_W       = $clog2(DATA_BITS + 1);
    localparam int CW          = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CYC_W-1:0] BIT_LAST_CYC  = CYC_W'(CYCLES - 1);
    localparam logic [CYC_W-1:0] STOP_LAST_CYC = CYC_W'(STOP_CYCLES - 1);
    localparam logic [BIT_W-1:0] LAST_BIT      = BIT_W'(DATA_BITS - 1);

    uart_state_t          state_reg, state_next;
    logic [CYC_W-1:0]     cyc_cnt_reg, cyc_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic                 tx_out_reg;
    logic                 line_bit;
    logic                 pop;
    logic [DATA_BITS-1:0] head_data;
    logic [DATA_BITS-1:0] head_ordered;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        count;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s.tx_valid),
        .push_data (s.tx_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    // Reorder the popped word once so the shifter always sends bit 0 next.
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_order
        assign head_ordered[gi] = (MSB_FIRST != 0) ? head_data[DATA_BITS-1-gi] : head_data[gi];
    end

    assign s.tx_ready = !fifo_full;
    assign fifo_count = count;
    assign tx_out     = tx_out_reg;
    assign busy       = (state_reg != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cyc_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            tx_out_reg  <= 1'b1;
        end else begin
            state_reg   <= state_next;
            cyc_cnt_reg <= cyc_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            parity_reg  <= parity_next;
            tx_out_reg  <= line_bit;
        end
    end

    // The FIFO read is registered, so the popped word is only valid from the
    // cycle after the pop; it is latched into the shifter at the end of START.
    always_comb begin
        state_next   = state_reg;
        cyc_cnt_next = cyc_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        parity_next  = parity_reg;
        pop          = 1'b0;
        line_bit     = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                cyc_cnt_next = '0;
                bit_cnt_next = '0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end

            ST_START: begin
                line_bit = 1'b0;
                if (cyc_cnt_reg == BIT_LAST_CYC) begin
                    cyc_cnt_next = '0;
                    bit_cnt_next = '0;
                    shift_next   = head_ordered;
                    parity_next  = (^head_data) ^ (PARITY == PAR_ODD);
                    state_next   = ST_DATA;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end
            end

            ST_DATA: begin
                line_bit = shift_reg[0];
                if (cyc_cnt_reg == BIT_LAST_CYC) begin
                    cyc_cnt_next = '0;
                    shift_next   = shift_reg >> 1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_next = '0;
                        state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end
            end

            ST_PARITY: begin
                line_bit = parity_reg;
                if (cyc_cnt_reg == BIT_LAST_CYC) begin
                    cyc_cnt_next = '0;
                    state_next   = ST_STOP;
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end
            end

            ST_STOP: begin
                line_bit = 1'b1;
                if (cyc_cnt_reg == STOP_LAST_CYC) begin
                    cyc_cnt_next = '0;
                    // Chain straight into the next frame so queued words leave with no idle gap.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
